// File: rtl/prach_buffer_rd.sv
// PRACH capture-buffer reader: picks a ready channel round-robin, streams its frame
// through a credit-limited read pipe and skid FIFO, then acknowledges the buffer.
module prach_buffer_rd #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned FRAME_LEN  = 1536,
  parameter int unsigned RD_LAT     = 3,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    done_req,
  output logic [NUM_CH-1:0]    done_ack,
  output logic [10:0]          rd_addr,
  output logic [NUM_CH-1:0]    rd_en,
  input  logic [NUM_CH*32-1:0] rd_data,
  output logic [31:0]          dout_data,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [7:0]           dout_chn,
  output logic                 dout_last,
  output logic                 busy
);
  localparam int unsigned AW    = 11;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_ACK} state_e;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_t;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] rd_en_q, rd_en_d, done_ack_q, done_ack_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic [CH_W-1:0]   cur_ch_q, cur_ch_d, rr_ptr_q, rr_ptr_d, sel_ch;
  logic              busy_q, busy_d, sel_found, credit_ok, drained;
  logic [CNT_W-1:0]  inflight, fifo_cnt_q;
  logic [RD_LAT-1:0] vld_q, last_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  word_t             mem_q [FIFO_DEPTH];
  word_t             push_word;
  logic              push, pop;

  // First pending request at or after rr_ptr, cyclically
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = (32'(rr_ptr_q) + i) % NUM_CH;
      if (!sel_found && done_req[CH_W'(idx)]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'(idx);
      end
    end
  end

  // The read being presented this cycle counts as in flight, so the FIFO can never overflow
  always_comb begin
    inflight = CNT_W'(|rd_en_q);
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CNT_W'(vld_q[i]);
    end
    credit_ok = (inflight + fifo_cnt_q) < CNT_W'(FIFO_DEPTH);
    drained   = (inflight == '0) && (fifo_cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sel_found) state_d = S_READ;
      S_READ:  if (rd_addr_q == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN: if (drained) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; the first read is issued on entry to READ
  always_comb begin
    rd_en_d    = '0;
    rd_addr_d  = rd_addr_q;
    done_ack_d = '0;
    cur_ch_d   = cur_ch_q;
    rr_ptr_d   = rr_ptr_q;
    busy_d     = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          cur_ch_d  = sel_ch;
          rd_addr_d = '0;
          rd_en_d   = NUM_CH'(1) << sel_ch;
        end
      end
      S_READ: begin
        if (rd_addr_q != LAST_ADDR && credit_ok) begin
          rd_addr_d = rd_addr_q + AW'(1);
          rd_en_d   = NUM_CH'(1) << cur_ch_q;
        end
      end
      S_DRAIN: begin
        if (state_d == S_ACK) done_ack_d = NUM_CH'(1) << cur_ch_q;
      end
      S_ACK: begin
        rr_ptr_d = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en_q    <= '0;
      rd_addr_q  <= '0;
      done_ack_q <= '0;
      cur_ch_q   <= '0;
      rr_ptr_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      done_ack_q <= done_ack_d;
      cur_ch_q   <= cur_ch_d;
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q[0]  <= |rd_en_q;
      last_q[0] <= (rd_addr_q == LAST_ADDR);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  // Unselected buffers return zero, so OR-ing all slices yields the active channel's word
  always_comb begin
    push_word      = '0;
    push_word.last = last_q[RD_LAT-1];
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      push_word.data = push_word.data | rd_data[32*c +: 32];
    end
  end

  assign push = vld_q[RD_LAT-1];
  assign pop  = dout_valid && dout_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
      else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign dout_valid = (fifo_cnt_q != '0);
  assign dout_data  = mem_q[rd_ptr_q].data;
  assign dout_last  = dout_valid && mem_q[rd_ptr_q].last;
  assign dout_chn   = 8'(cur_ch_q);
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign done_ack   = done_ack_q;
  assign busy       = busy_q;

endmodule

// File: doc/prach_buffer_rd.md
Name: prach_buffer_rd

Overview:
- Downstream consumer of the per-channel PRACH capture buffers (prach_buffer_ch instances).
- Waits for any buffer's done_req, reads that buffer's 1536 samples in address order, and streams them out on a ready/valid interface tagged with the channel number.
- Acknowledges the buffer once its whole frame has been accepted downstream.
- Output feeds the PRACH FFT/correlation stage.

Parameters:
- NUM_CH, 4: number of buffer channels served; 1..16.
- FRAME_LEN, 1536: samples per frame; read addresses 0..FRAME_LEN-1.
- RD_LAT, 3: buffer read latency in cycles, from rd_en/rd_addr to rd_data.
- FIFO_DEPTH, 8: output skid FIFO depth; must be >= RD_LAT+2.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous reset, active-low.
- done_req  in  NUM_CH  per-channel frame-ready level from the buffers; held until acked.
- done_ack  out  NUM_CH  per-channel one-cycle acknowledge pulse.
- rd_addr  out  11  shared buffer read address.
- rd_en  out  NUM_CH  per-channel read enable; one-hot or zero.
- rd_data  in  NUM_CH*32  concatenated buffer outputs, channel c at [32c+31:32c]. A buffer returns 0 when it was not enabled.
- dout_data  out  32  sample, {imag[31:16], real[15:0]}.
- dout_valid  out  1  output valid.
- dout_ready  in  1  downstream ready.
- dout_chn  out  8  channel of the current frame, zero-extended.
- dout_last  out  1  high on the final sample of a frame (address FRAME_LEN-1).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low at clk edge):
  - Outputs: done_ack=0, rd_en=0, rd_addr=0, dout_valid=0, dout_last=0, dout_chn=0, busy=0.
  - Internal: FIFO emptied, in-flight pipe cleared, round-robin pointer=0, FSM=IDLE.
  - Applies mid-frame too: the frame is abandoned, no ack is issued, and the buffer's done_req stays pending.
- FSM states: IDLE, READ, DRAIN, ACK.
- IDLE:
  - If any done_req is set, select the first set bit at or after rr_ptr, cyclically. Latch it as cur_ch, set rd_addr=0, go to READ.
  - Selection and entry to READ occur in the same cycle.
- READ:
  - Issue a read (rd_en[cur_ch]=1 with rd_addr) only when inflight+fifo_count < FIFO_DEPTH. This credit rule guarantees the FIFO never overflows.
  - rd_addr increments by 1 after each issued read.
  - When address FRAME_LEN-1 is issued, go to DRAIN.
  - rd_en is never asserted for any channel other than cur_ch.
- Read return:
  - A RD_LAT-deep shift register carries {valid, last}.
  - At the output of the shift register, the data word is the bitwise OR of all rd_data channel slices. This is valid because non-enabled buffers return 0.
  - The word is pushed into the FIFO with its last flag.
  - inflight = number of set valid bits in the shift register.
- DRAIN: wait until inflight=0, and the FIFO is empty, and the last word has been accepted (dout_valid & dout_ready with dout_last=1). Then go to ACK.
- ACK:
  - done_ack[cur_ch]=1 for exactly one cycle.
  - rr_ptr = (cur_ch+1) mod NUM_CH.
  - Next state is IDLE. The buffer drops done_req on the following edge, so IDLE never re-sees the acked request.
- Output interface:
  - dout_valid = FIFO not empty. dout_data and dout_last come from the FIFO head. dout_chn = cur_ch.
  - Data, last and valid are stable while valid & !ready.
  - Simultaneous push and pop in one cycle is allowed; the count is unchanged.
- Throughput and latency:
  - With dout_ready tied high: one sample per cycle.
  - First dout_valid appears RD_LAT+1 cycles after entering READ.
  - Frame-to-frame gap is at most RD_LAT+4 cycles.
- done_req bits that rise during a frame are held pending and served in round-robin order afterwards.

Test Plan:
- Single frame: NUM_CH=4, done_req=0b0001, buffer model returns addr+0x10000*ch, dout_ready=1.
  - Expect 1536 words with data 0x00000000..0x000005FF, chn=0.
  - dout_last only on word 1535; first valid 4 cycles after READ entry.
  - done_ack[0] is a single pulse.
- Backpressure: same stimulus, dout_ready toggling at random with 30% duty.
  - Expect an identical word sequence with no drop or duplicate.
  - FIFO count never exceeds 8; data is stable while stalled.
- Round-robin: done_req=0b1010 asserted at once.
  - Expect frames in order chn 1 then chn 3.
  - Then assert done_req[1] and done_req[2] together, with rr_ptr=0 after chn 3.
  - Expect chn 1 then chn 2; each ack goes to the correct bit only.
- Mid-frame request: assert done_req[2] while chn 0 is at address 700.
  - Expect chn 0 to finish all 1536 words, ACK, then chn 2 to start within RD_LAT+4 cycles.
- Reset mid-frame: rst_n low for 1 cycle at address 900.
  - Expect all outputs at reset values the next cycle and no done_ack.
  - With done_req[0] still high, the frame restarts from address 0.
- Rd_en exclusivity: over all of the above, at most one bit of rd_en is set per cycle, and only bit cur_ch.
